// File: rtl/stopwatch_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_display_pkg
// Brief    : Shared segment codes, anode constants and digit-index type for
//            the stopwatch display path.
// Revision : 1.0 - initial release
// ============================================================================
package stopwatch_display_pkg;

    typedef logic [1:0] digit_idx_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam logic [3:0] AN_OFF = 4'b1111;

    // The min_one digit carries the mm.ss separator dot
    localparam digit_idx_t IDX_DP = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_decoder
// Brief    : 4-bit BCD to active-low seven-segment code; non-BCD shows a dash.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_DIGIT[0];
            4'd1:    o_seg = SEG_DIGIT[1];
            4'd2:    o_seg = SEG_DIGIT[2];
            4'd3:    o_seg = SEG_DIGIT[3];
            4'd4:    o_seg = SEG_DIGIT[4];
            4'd5:    o_seg = SEG_DIGIT[5];
            4'd6:    o_seg = SEG_DIGIT[6];
            4'd7:    o_seg = SEG_DIGIT[7];
            4'd8:    o_seg = SEG_DIGIT[8];
            4'd9:    o_seg = SEG_DIGIT[9];
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_display
// Brief    : 4-digit multiplexed common-anode display driver with guard
//            blanking, frame-coherent digit capture and adjust-mode blinking.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4,
    parameter int BLINK_DIV   = 25000000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sec_one,
    input  logic [3:0] sec_ten,
    input  logic [3:0] min_one,
    input  logic [3:0] min_ten,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] c_ref_last   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] c_guard      = CW'(GUARD);
    localparam logic [BW-1:0] c_blink_last = BW'(BLINK_DIV - 1);

    logic [CW-1:0]      refresh_cnt_q, refresh_cnt_d;
    digit_idx_t         idx_q, idx_d;
    logic [3:0][3:0]    shadow_q, shadow_d;
    logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               w_tick;
    logic               w_blink_tc;
    logic               w_in_guard;
    logic               w_field_off;
    logic [3:0]         w_cur_digit;
    logic [6:0]         w_dec_seg;

    assign w_cur_digit = shadow_q[idx_q];

    seven_seg_decoder u_decoder (
        .i_bcd (w_cur_digit),
        .o_seg (w_dec_seg)
    );

    always_comb begin
        w_tick        = (refresh_cnt_q == c_ref_last);
        refresh_cnt_d = w_tick ? '0 : refresh_cnt_q + CW'(1);
        idx_d         = w_tick ? idx_q + 2'd1 : idx_q;

        // Latch a whole new time value only at the frame boundary
        shadow_d = shadow_q;
        if (w_tick && (idx_q == 2'd3)) begin
            shadow_d = {min_ten, min_one, sec_ten, sec_one};
        end

        w_blink_tc  = (blink_cnt_q == c_blink_last);
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (adj) begin
            blink_cnt_d = w_blink_tc ? '0 : blink_cnt_q + BW'(1);
            phase_d     = phase_q ^ w_blink_tc;
        end

        // sel=1 selects seconds (indices 0-1), sel=0 minutes (indices 2-3)
        w_in_guard  = (refresh_cnt_q < c_guard);
        w_field_off = adj && phase_q && (sel ? ~idx_q[1] : idx_q[1]);

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!w_in_guard && !w_field_off) begin
            an_d[idx_q] = 1'b0;
            seg_d       = w_dec_seg;
            dp_d        = (idx_q != IDX_DP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_display
// Brief    : Self-checking bench for stopwatch_display with a time-indexed
//            reference model of the scan, capture and blink behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stopwatch_display;

    localparam int R     = 8;
    localparam int G     = 2;
    localparam int B     = 16;
    localparam int FRAME = 4 * R;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sec_one = 4'd0, sec_ten = 4'd0, min_one = 4'd0, min_ten = 4'd0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    stopwatch_display #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sec_one (sec_one),
        .sec_ten (sec_ten),
        .min_one (min_one),
        .min_ten (min_ten),
        .adj     (adj),
        .sel     (sel),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Reference model: k = clock edges since reset release, m = consecutive
    // edges with adj high. Everything else follows from plain arithmetic.
    logic [6:0] seg_tab [16];
    logic [3:0] sh [4];
    int         k = 0;
    int         m = 0;
    logic [3:0] exp_an  = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp  = 1'b1;

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
        for (int i = 0; i < 4; i++) sh[i] = 4'd0;
    end

    function automatic int slot_of(int kk);
        return (kk / R) % 4;
    endfunction

    function automatic bit visible(int kk, int mm);
        int  slot  = slot_of(kk);
        bit  blink = adj && (((mm / B) % 2) == 1) && (sel ? (slot < 2) : (slot >= 2));
        return ((kk % R) >= G) && !blink;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= 0;
            m       <= 0;
            for (int i = 0; i < 4; i++) sh[i] <= 4'd0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
            exp_dp  <= 1'b1;
        end else begin
            exp_an  <= visible(k, m) ? (4'hF ^ (4'b0001 << slot_of(k))) : 4'hF;
            exp_seg <= visible(k, m) ? seg_tab[sh[slot_of(k)]] : 7'h7F;
            exp_dp  <= visible(k, m) ? (slot_of(k) != 2) : 1'b1;
            if ((k % FRAME) == FRAME - 1) begin
                sh[0] <= sec_one; sh[1] <= sec_ten; sh[2] <= min_one; sh[3] <= min_ten;
            end
            k <= k + 1;
            m <= adj ? m + 1 : 0;
        end
    end

    task automatic test_reset;
        sec_one = 4'd1; sec_ten = 4'd2; min_one = 4'd3; min_ten = 4'd4;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            errors++;
            $display("FAIL reset_hold: an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 2 * FRAME; e++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL reset_scan e=%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                         e, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (e - 1 == 32 || e - 1 == 41 || e - 1 == 56) begin
                checks++;
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL reset_guard e=%0d: an=%b want 1111", e, an);
                end
            end
            if (e - 1 == 34 || e - 1 == 42 || e - 1 == 50 || e - 1 == 58) begin
                logic [3:0] want_an;
                logic [6:0] want_seg;
                case (e - 1)
                    34:      begin want_an = 4'b1110; want_seg = 7'b1111001; end
                    42:      begin want_an = 4'b1101; want_seg = 7'b0100100; end
                    50:      begin want_an = 4'b1011; want_seg = 7'b0110000; end
                    default: begin want_an = 4'b0111; want_seg = 7'b0011001; end
                endcase
                checks++;
                if (an !== want_an || seg !== want_seg) begin
                    errors++;
                    $display("FAIL reset_digit e=%0d: an=%b seg=%b want %b/%b",
                             e, an, seg, want_an, want_seg);
                end
            end
        end
    endtask

    task automatic test_tear;
        int n;
        bit seen;
        sec_one = 4'd5;
        n = 0;
        do begin @(negedge clk); n++; end while ((k % FRAME) != 0 && n < 100);
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL tear_wrap_timeout: waited %0d cycles, want < 100", n);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 7'b0010010) begin
            errors++;
            $display("FAIL tear_before: an=%b seg=%b want 1110/0010010", an, seg);
        end
        repeat (4) @(negedge clk);
        sec_one = 4'd6;
        seen = 1'b0;
        for (int e = 0; e < 2 * FRAME; e++) begin
            @(negedge clk);
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL tear_scan e=%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                         e, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
            if (an === 4'b1110 && !seen) begin
                seen = 1'b1;
                checks++;
                if (seg !== 7'b0000010) begin
                    errors++;
                    $display("FAIL tear_after: seg=%b want 0000010", seg);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL tear_no_idx0: seen=0 want 1");
        end
    endtask

    task automatic test_dp;
        for (int e = 0; e < 3 * FRAME; e++) begin
            @(negedge clk);
            if (e % 11 == 0) begin
                sec_one = 4'($urandom_range(0, 9)); sec_ten = 4'($urandom_range(0, 5));
                min_one = 4'($urandom_range(0, 9)); min_ten = 4'($urandom_range(0, 5));
            end
            checks++;
            if (dp !== (an !== 4'b1011)) begin
                errors++;
                $display("FAIL dp_rule e=%0d: an=%b dp=%b want dp=%b", e, an, dp, an !== 4'b1011);
            end
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL dp_scan e=%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                         e, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_invalid;
        int hits;
        min_ten = 4'hC;
        sec_one = 4'($urandom_range(0, 9));
        repeat (2 * FRAME) @(negedge clk);
        hits = 0;
        for (int e = 0; e < FRAME; e++) begin
            @(negedge clk);
            if (an === 4'b0111) begin
                hits++;
                checks++;
                if (seg !== 7'b0111111) begin
                    errors++;
                    $display("FAIL invalid_dash: seg=%b want 0111111", seg);
                end
            end
        end
        checks++;
        if (hits != R - G) begin
            errors++;
            $display("FAIL invalid_slot_len: lit=%0d want %0d", hits, R - G);
        end
    endtask

    task automatic test_blink;
        int n, sec_lit, min_lit, blanks;
        n = 0;
        while ((k % FRAME) != 20 && n < 100) begin @(negedge clk); n++; end
        adj = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            sel = (pass == 0);
            sec_lit = 0; min_lit = 0;
            for (int e = 0; e < 2 * FRAME; e++) begin
                @(negedge clk);
                if (an === 4'b1110 || an === 4'b1101) sec_lit++;
                if (an === 4'b1011 || an === 4'b0111) min_lit++;
                checks++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    errors++;
                    $display("FAIL blink_scan sel=%0d e=%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                             sel, e, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
            checks++;
            if (sel ? (min_lit != 24 || sec_lit == 0 || sec_lit >= 24)
                    : (sec_lit != 24 || min_lit == 0 || min_lit >= 24)) begin
                errors++;
                $display("FAIL blink_counts sel=%0d: sec_lit=%0d min_lit=%0d want unselected=24, 0<selected<24",
                         sel, sec_lit, min_lit);
            end
        end
        adj = 1'b0;
        repeat (2) @(negedge clk);
        blanks = 0;
        for (int e = 0; e < FRAME; e++) begin
            @(negedge clk);
            if (an === 4'b1111) blanks++;
        end
        checks++;
        if (blanks != 4 * G) begin
            errors++;
            $display("FAIL blink_release: blank_cycles=%0d want %0d", blanks, 4 * G);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        while (an !== 4'b1011 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL rstmid_timeout: waited %0d cycles, want < 100", n);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            if (e == 1 || e == 2) begin
                checks++;
                if (an !== 4'b1111) begin
                    errors++;
                    $display("FAIL rstmid_guard e=%0d: an=%b want 1111", e, an);
                end
            end
            if (e == 3) begin
                checks++;
                if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_restart: an=%b seg=%b dp=%b want 1110/1000000/1", an, seg, dp);
                end
            end
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL rstmid_scan e=%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                         e, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    task automatic test_random;
        for (int e = 0; e < 600; e++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                sec_one = 4'($urandom); sec_ten = 4'($urandom);
                min_one = 4'($urandom); min_ten = 4'($urandom);
            end
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 19) == 0) sel = ~sel;
            checks++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                errors++;
                $display("FAIL random_scan e=%0d: an=%b seg=%b dp=%b want %b/%b/%b",
                         e, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tear();
        test_dp();
        test_invalid();
        test_blink();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
